// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one shared single-port RAM bank.
// Each accepted request runs IDLE -> ACCESS -> RESP, so at most one is in
// flight. Contention is resolved by a round-robin priority pointer.
module ram_arbiter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  output logic              a_ready,
  output logic              b_ready,
  output logic              a_rsp_valid,
  output logic              b_rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [WIDTH-1:0]  ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [WIDTH-1:0]  ram_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } req_t;

  state_e            state_q, state_d;
  logic              prio_b_q;     // 1: B wins a tie, 0: A wins a tie
  logic              win_b_q;      // owner of the transaction in flight
  logic              ram_load_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic [WIDTH-1:0]  ram_in_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              a_rsp_q;
  logic              b_rsp_q;
  logic              busy_q;

  logic              accept;
  logic              grant_b;
  req_t              sel_req;

  // Next state, combinational grants and selection of the winning payload
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    grant_b = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_valid || b_valid) begin
          accept  = 1'b1;
          grant_b = b_valid && (!a_valid || prio_b_q);
          a_ready = !grant_b;
          b_ready = grant_b;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    sel_req = grant_b ? req_t'{we: b_we, addr: b_addr, data: b_data}
                      : req_t'{we: a_we, addr: a_addr, data: a_data};
  end

  // State register and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Latch the accepted request onto the RAM port; write strobe lasts one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_b_q       <= 1'b0;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
    end else begin
      ram_load_q <= accept && sel_req.we;
      if (accept) begin
        win_b_q       <= grant_b;
        ram_address_q <= sel_req.addr;
        ram_in_q      <= sel_req.data;
      end
    end
  end

  // Capture response data leaving ACCESS and strobe the owner's rsp_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data_q <= '0;
      a_rsp_q    <= 1'b0;
      b_rsp_q    <= 1'b0;
    end else begin
      a_rsp_q <= 1'b0;
      b_rsp_q <= 1'b0;
      if (state_q == S_ACCESS) begin
        rsp_data_q <= ram_load_q ? ram_in_q : ram_out;
        a_rsp_q    <= !win_b_q;
        b_rsp_q    <= win_b_q;
      end
    end
  end

  // Round-robin pointer hands priority to the loser once the response is done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_b_q <= 1'b0;
    end else if (state_q == S_RESP) begin
      prio_b_q <= !win_b_q;
    end
  end

  assign ram_load    = ram_load_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign rsp_data    = rsp_data_q;
  assign a_rsp_valid = a_rsp_q;
  assign b_rsp_valid = b_rsp_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM bank model on the RAM port, directed
// scenarios and a randomized phase, all checked against a transaction-level
// reference that tracks cycles since acceptance, the tie-break owner and
// memory contents.
module tb_ram_arbiter;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              a_valid, a_we, b_valid, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]  a_data, b_data;
  logic              a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [WIDTH-1:0]  rsp_data, ram_in, ram_out;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_load, busy;

  ram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .a_ready(a_ready), .b_ready(b_ready),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .rsp_data(rsp_data), .ram_in(ram_in), .ram_address(ram_address),
    .ram_load(ram_load), .ram_out(ram_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared RAM bank: synchronous write, combinational read
  logic             init_ram;
  logic [WIDTH-1:0] tb_ram [DEPTH];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < int'(DEPTH); i++) tb_ram[i] <= WIDTH'(32'hA000 + i * 32'h111);
    end else if (ram_load) begin
      tb_ram[ram_address] <= ram_in;
    end
  end
  assign ram_out = tb_ram[ram_address];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_age counts cycles since acceptance (0 = nothing in flight)
  int               m_age;
  bit               m_prio_b;
  bit               m_win_b;
  logic             m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WIDTH-1:0] m_data;
  logic [ADDR_W-1:0] m_ram_addr;
  logic [WIDTH-1:0] m_ram_in;
  logic [WIDTH-1:0] m_rsp;
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               acc_a, acc_b;

  task automatic model_reset();
    m_age      = 0;
    m_prio_b   = 1'b0;
    m_win_b    = 1'b0;
    m_ram_addr = '0;
    m_ram_in   = '0;
    m_rsp      = '0;
  endtask

  function automatic bit exp_grant_b();
    return b_valid && (!a_valid || m_prio_b);
  endfunction

  task automatic check_outputs();
    bit idle_req;
    idle_req = (m_age == 0) && (a_valid || b_valid);
    check_eq("a_ready", 32'(a_ready), 32'(idle_req && !exp_grant_b()));
    check_eq("b_ready", 32'(b_ready), 32'(idle_req && exp_grant_b()));
    check_eq("busy", 32'(busy), 32'(m_age != 0));
    check_eq("ram_load", 32'(ram_load), 32'((m_age == 1) && m_we));
    check_eq("a_rsp_valid", 32'(a_rsp_valid), 32'((m_age == 2) && !m_win_b));
    check_eq("b_rsp_valid", 32'(b_rsp_valid), 32'((m_age == 2) && m_win_b));
    check_eq("ram_address", 32'(ram_address), 32'(m_ram_addr));
    check_eq("ram_in", 32'(ram_in), 32'(m_ram_in));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_rsp));
  endtask

  // Advance the model across the upcoming clock edge
  task automatic model_advance();
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (m_age == 0) begin
      if (a_valid || b_valid) begin
        m_win_b = exp_grant_b();
        acc_b   = m_win_b;
        acc_a   = !m_win_b;
        m_we    = m_win_b ? b_we   : a_we;
        m_addr  = m_win_b ? b_addr : a_addr;
        m_data  = m_win_b ? b_data : a_data;
        m_ram_addr = m_addr;
        m_ram_in   = m_data;
        m_age   = 1;
      end
    end else if (m_age == 1) begin
      if (m_we) begin
        m_mem[m_addr] = m_data;
        m_rsp = m_data;
      end else begin
        m_rsp = m_mem[m_addr];
      end
      m_age = 2;
    end else begin
      m_prio_b = !m_win_b;
      m_age    = 0;
    end
  endtask

  task automatic drive(input logic av, input logic awe, input logic [ADDR_W-1:0] aad,
                       input logic [WIDTH-1:0] ad, input logic bv, input logic bwe,
                       input logic [ADDR_W-1:0] bad, input logic [WIDTH-1:0] bd);
    a_valid = av; a_we = awe; a_addr = aad; a_data = ad;
    b_valid = bv; b_we = bwe; b_addr = bad; b_data = bd;
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, advance the model
  task automatic step(input logic av, input logic awe, input logic [ADDR_W-1:0] aad,
                      input logic [WIDTH-1:0] ad, input logic bv, input logic bwe,
                      input logic [ADDR_W-1:0] bad, input logic [WIDTH-1:0] bd);
    @(posedge clk);
    #1;
    drive(av, awe, aad, ad, bv, bwe, bad, bd);
    #1;
    check_outputs();
    model_advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Cycle in which reset_n pulses low mid-cycle
  task automatic step_reset();
    @(posedge clk);
    #1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    check_outputs();
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #3;
    reset_n = 1'b1;
  endtask

  logic             ra_v, ra_we, rb_v, rb_we;
  logic [ADDR_W-1:0] ra_addr, rb_addr;
  logic [WIDTH-1:0] ra_data, rb_data;

  initial begin
    reset_n  = 1'b0;
    init_ram = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = WIDTH'(32'hA000 + i * 32'h111);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    init_ram = 1'b0;
    check_outputs();
    #3;
    reset_n = 1'b1;

    // Write then read the same address from A
    step(1, 1, 3'd5, 16'h1234, 0, 0, '0, '0);
    idle(2);
    step(1, 0, 3'd5, 16'h0000, 0, 0, '0, '0);
    idle(2);
    check_eq("rd_after_wr", 32'(rsp_data), 32'h1234);

    // Contention with both held valid: grants alternate
    for (int i = 0; i < 12; i++) step(1, 0, 3'd1, '0, 1, 0, 3'd6, '0);
    idle(3);

    // B alone, three back-to-back reads
    for (int i = 0; i < 9; i++) step(0, 0, '0, '0, 1, 0, ADDR_W'(i / 3), '0);
    idle(3);

    // B arrives while A is busy, waits for IDLE
    step(1, 1, 3'd3, 16'h5A5A, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 1, 3'd4, 16'hC3C3);
    step(0, 0, '0, '0, 1, 1, 3'd4, 16'hC3C3);
    step(0, 0, '0, '0, 1, 1, 3'd4, 16'hC3C3);
    idle(3);

    // Withdrawal while busy
    step(1, 0, 3'd0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 1, 3'd7, 16'hDEAD);
    idle(4);

    // Reset during ACCESS of a write
    step(1, 1, 3'd2, 16'hBEEF, 0, 0, '0, '0);
    step_reset();
    check_eq("abort_nowrite", 32'(tb_ram[2]), 32'(m_mem[2]));
    step(1, 0, 3'd2, '0, 0, 0, '0, '0);
    idle(3);

    // Randomized traffic with holds and withdrawals
    ra_v = 0; rb_v = 0;
    ra_we = 0; rb_we = 0; ra_addr = '0; rb_addr = '0; ra_data = '0; rb_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ra_v) begin
        if ($urandom_range(0, 1) == 1) begin
          ra_v = 1; ra_we = 1'($urandom_range(0, 1));
          ra_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); ra_data = WIDTH'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        ra_v = 0;
      end
      if (!rb_v) begin
        if ($urandom_range(0, 1) == 1) begin
          rb_v = 1; rb_we = 1'($urandom_range(0, 1));
          rb_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); rb_data = WIDTH'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rb_v = 0;
      end
      step(ra_v, ra_we, ra_addr, ra_data, rb_v, rb_we, rb_addr, rb_data);
      if (acc_a) ra_v = 0;
      if (acc_b) rb_v = 0;
    end
    idle(3);

    for (int i = 0; i < int'(DEPTH); i++) check_eq("ram_final", 32'(tb_ram[i]), 32'(m_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
